mandel_iter_pipe: RTL and testbench

//  Parametrised, multi-stage successor of diverge_pipe: STAGES unrolled Mandelbrot iteration stages, one per register slice.

---
 rtl/mandel_iter_pipe.sv | 133 +++++++++++++
 tb/tb_mandel_iter_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_iter_pipe.sv
// Unrolled Mandelbrot iteration pipeline: STAGES register slices, each applying z <- z^2 + c once.
// Escape, overflow and iteration-cap detection; global stall driven by the output handshake.
module mandel_iter_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 13,
    parameter int ITER_W = 8,
    parameter int STAGES = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_y,
    input  logic [WIDTH-1:0]  in_c1,
    input  logic [WIDTH-1:0]  in_c2,
    input  logic [ITER_W-1:0] in_div,
    input  logic              in_done,
    input  logic [ITER_W-1:0] max_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_x,
    output logic [WIDTH-1:0]  out_y,
    output logic [WIDTH-1:0]  out_c1,
    output logic [WIDTH-1:0]  out_c2,
    output logic [ITER_W-1:0] out_div,
    output logic              out_done
);

    // Handshake: a point moves from in_* into the pipe on a rising edge where in_valid & in_ready;
    // it leaves on an edge where out_valid & out_ready. The whole pipe advances together or holds.

    localparam int XW = 2 * WIDTH + 2;
    localparam logic [2*WIDTH:0] ESC_LIM = (2 * WIDTH + 1)'(4) << (2 * FRAC);

    typedef struct packed {
        logic              valid;
        logic [WIDTH-1:0]  x;
        logic [WIDTH-1:0]  y;
        logic [WIDTH-1:0]  c1;
        logic [WIDTH-1:0]  c2;
        logic [ITER_W-1:0] div;
        logic              done;
    } point_t;

    point_t stage_q  [STAGES];
    point_t stage_in [STAGES];
    point_t stage_d  [STAGES];
    logic   en;

    function automatic point_t step(input point_t p, input logic [ITER_W-1:0] cap);
        logic signed [2*WIDTH-1:0] xx, yy, xy;
        logic        [2*WIDTH:0]   mag;
        logic signed [XW-1:0]      xx_e, yy_e, xy_e, c1_e, c2_e, nx, ny;
        logic        [ITER_W:0]    div_inc;
        logic                      esc, ovf_x, ovf_y;
        point_t                    r;
        r       = p;
        xx      = $signed(p.x) * $signed(p.x);
        yy      = $signed(p.y) * $signed(p.y);
        xy      = $signed(p.x) * $signed(p.y);
        mag     = {1'b0, xx} + {1'b0, yy};
        esc     = (mag >= ESC_LIM);
        xx_e    = {{2{xx[2*WIDTH-1]}}, xx};
        yy_e    = {{2{yy[2*WIDTH-1]}}, yy};
        xy_e    = {{2{xy[2*WIDTH-1]}}, xy};
        c1_e    = {{(XW-WIDTH){p.c1[WIDTH-1]}}, p.c1};
        c2_e    = {{(XW-WIDTH){p.c2[WIDTH-1]}}, p.c2};
        nx      = ((xx_e - yy_e) >>> FRAC) + c1_e;
        ny      = ((xy_e <<< 1) >>> FRAC) + c2_e;
        // In range only when the bits above the WIDTH sign bit all copy it.
        ovf_x   = !((&nx[XW-1:WIDTH-1]) || !(|nx[XW-1:WIDTH-1]));
        ovf_y   = !((&ny[XW-1:WIDTH-1]) || !(|ny[XW-1:WIDTH-1]));
        div_inc = {1'b0, p.div} + 1'b1;
        if (p.done) begin
            r = p;
        end else if (esc || ovf_x || ovf_y) begin
            r.done = 1'b1;
        end else if (&p.div) begin
            // Counter saturated: finish the point rather than wrap.
            r.done = 1'b1;
        end else begin
            r.x    = nx[WIDTH-1:0];
            r.y    = ny[WIDTH-1:0];
            r.div  = div_inc[ITER_W-1:0];
            r.done = (div_inc >= {1'b0, cap});
        end
        return r;
    endfunction

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    always_comb begin
        stage_in[0].valid = in_valid;
        stage_in[0].x     = in_x;
        stage_in[0].y     = in_y;
        stage_in[0].c1    = in_c1;
        stage_in[0].c2    = in_c2;
        stage_in[0].div   = in_div;
        stage_in[0].done  = in_done;
        for (int s = 1; s < STAGES; s++) begin
            stage_in[s] = stage_q[s-1];
        end
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stage_d[s] = step(stage_in[s], max_iter);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign out_x     = stage_q[STAGES-1].x;
    assign out_y     = stage_q[STAGES-1].y;
    assign out_c1    = stage_q[STAGES-1].c1;
    assign out_c2    = stage_q[STAGES-1].c2;
    assign out_div   = stage_q[STAGES-1].div;
    assign out_done  = stage_q[STAGES-1].done;

endmodule

// File: tb/tb_mandel_iter_pipe.sv
// Bench for mandel_iter_pipe: directed corner points plus randomized streams with random
// backpressure, scored against an iterate-until-finished reference model.
module tb_mandel_iter_pipe;

  localparam int WIDTH  = 16;
  localparam int FRAC   = 13;
  localparam int ITER_W = 8;
  localparam int STAGES = 4;
  localparam int PW     = 4 * WIDTH + ITER_W + 1;

  logic              clk;
  logic              rst;
  logic              in_valid, in_ready, in_done;
  logic [WIDTH-1:0]  in_x, in_y, in_c1, in_c2;
  logic [ITER_W-1:0] in_div, max_iter;
  logic              out_valid, out_ready, out_done;
  logic [WIDTH-1:0]  out_x, out_y, out_c1, out_c2;
  logic [ITER_W-1:0] out_div;
  logic [PW-1:0]     out_bus;

  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  mandel_iter_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W), .STAGES(STAGES)) dut (
    .Clk(clk), .Reset(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_c1(in_c1), .in_c2(in_c2),
    .in_div(in_div), .in_done(in_done), .max_iter(max_iter),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_c1(out_c1), .out_c2(out_c2),
    .out_div(out_div), .out_done(out_done)
  );

  assign out_bus = {out_x, out_y, out_c1, out_c2, out_div, out_done};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: apply up to STAGES Mandelbrot iterations with plain integer arithmetic.
  function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] ix, iy, ic1, ic2,
                                          input logic [ITER_W-1:0] idiv, input logic idone,
                                          input logic [ITER_W-1:0] cap);
    longint x, y, c1, c2, xx, yy, xy, nx, ny, lo, hi, lim;
    int div, div_max;
    bit done;
    logic [WIDTH-1:0] rx, ry;
    logic [ITER_W-1:0] rd;
    x = longint'($signed(ix));
    y = longint'($signed(iy));
    c1 = longint'($signed(ic1));
    c2 = longint'($signed(ic2));
    div = int'(idiv);
    done = idone;
    lo = -(longint'(1) << (WIDTH - 1));
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lim = longint'(4) << (2 * FRAC);
    div_max = (1 << ITER_W) - 1;
    for (int s = 0; s < STAGES; s++) begin
      if (!done) begin
        xx = x * x;
        yy = y * y;
        xy = x * y;
        nx = ((xx - yy) >>> FRAC) + c1;
        ny = ((2 * xy) >>> FRAC) + c2;
        if (xx + yy >= lim) done = 1;
        else if (nx < lo || nx > hi || ny < lo || ny > hi) done = 1;
        else if (div == div_max) done = 1;
        else begin
          x = nx;
          y = ny;
          div = div + 1;
          if (div >= int'(cap)) done = 1;
        end
      end
    end
    rx = x[WIDTH-1:0];
    ry = y[WIDTH-1:0];
    rd = div[ITER_W-1:0];
    return {rx, ry, ic1, ic2, rd, done};
  endfunction

  // scoreboard: outputs are popped before new inputs are pushed in the same cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_out", 1'b1, 1'b0);
        else check("stream", out_bus, exp_q.pop_front());
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_x, in_y, in_c1, in_c2, in_div, in_done, max_iter));
    end
  end

  function automatic logic [WIDTH-1:0] rnd_coord();
    int v;
    v = int'($urandom_range(0, 32767)) - 16384;
    return v[WIDTH-1:0];
  endfunction

  task automatic rnd_point();
    in_x   = rnd_coord();
    in_y   = rnd_coord();
    in_c1  = rnd_coord();
    in_c2  = rnd_coord();
    in_div = ($urandom_range(0, 3) == 0) ? ITER_W'($urandom_range(0, 255)) : '0;
    in_done = ($urandom_range(0, 7) == 0);
  endtask

  // driver: send one point into an empty pipe, check latency and the final value
  task automatic directed(input string tag, input logic [WIDTH-1:0] x, y, c1, c2,
                          input logic [ITER_W-1:0] div, input logic done,
                          input logic [PW-1:0] exp);
    int lat;
    lat = 0;
    in_x = x; in_y = y; in_c1 = c1; in_c2 = c2; in_div = div; in_done = done;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    check({tag, "_lat"}, PW'(lat), PW'(STAGES));
    check(tag, out_bus, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int cyc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, PW'(exp_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PW-1:0] snap;
    logic [WIDTH-1:0] rx, ry, rc1, rc2;
    logic [ITER_W-1:0] rdv;
    int sent, cyc, base, accepted;
    bit fire;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; max_iter = 8'd255;
    in_x = '0; in_y = '0; in_c1 = '0; in_c2 = '0; in_div = '0; in_done = 1'b0;
    @(negedge clk);
    check("reset_valid", PW'(out_valid), '0);
    check("reset_bus", out_bus, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fill the pipe with the output blocked, then reset mid-cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < STAGES + 2; i++) begin
      rnd_point();
      in_done = 1'b0;
      @(posedge clk);
      #1;
    end
    check("full_ready", PW'(in_ready), '0);
    #2 rst = 1'b1;
    #1;
    check("midreset_valid", PW'(out_valid), '0);
    check("midreset_bus", out_bus, '0);
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // directed corner points
    directed("zero", '0, '0, '0, '0, '0, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0, 8'd4, 1'b0});
    directed("c_two", '0, '0, 16'h4000, '0, '0, 1'b0, {16'h4000, 16'h0, 16'h4000, 16'h0, 8'd1, 1'b1});
    directed("esc_in", 16'h6000, 16'h4000, '0, '0, '0, 1'b0, {16'h6000, 16'h4000, 16'h0, 16'h0, 8'd0, 1'b1});
    directed("ovf", 16'h3CCC, '0, 16'h3FFF, '0, '0, 1'b0, {16'h3CCC, 16'h0, 16'h3FFF, 16'h0, 8'd0, 1'b1});
    directed("div_sat", '0, '0, '0, '0, 8'd255, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0, 8'd255, 1'b1});
    directed("neg_c", '0, '0, 16'hE000, '0, '0, 1'b0, {16'h0, 16'h0, 16'hE000, 16'h0, 8'd4, 1'b0});
    max_iter = 8'd2;
    directed("cap", '0, '0, '0, '0, 8'd1, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0, 8'd2, 1'b1});
    rx = rnd_coord(); ry = rnd_coord(); rc1 = rnd_coord(); rc2 = rnd_coord();
    rdv = ITER_W'($urandom_range(0, 255));
    directed("passthru", rx, ry, rc1, rc2, rdv, 1'b1, {rx, ry, rc1, rc2, rdv, 1'b1});
    max_iter = 8'd255;
    drain("drain_directed");

    // ten back-to-back points with a three-cycle output stall
    base = n_out;
    sent = 0;
    cyc = 0;
    snap = '0;
    rnd_point();
    in_valid = 1'b1;
    while ((sent < 10 || n_out < base + 10) && cyc < 200) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid = (sent < 10);
      @(negedge clk);
      if (cyc == 5) snap = out_bus;
      if (cyc >= 5 && cyc < 8) begin
        check("stall_valid", PW'(out_valid), PW'(1));
        check("stall_ready", PW'(in_ready), '0);
      end
      if (cyc >= 6 && cyc <= 8) check("stall_hold", out_bus, snap);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        sent++;
        rnd_point();
      end
      cyc++;
    end
    check("stall_count", PW'(n_out - base), PW'(10));
    drain("drain_stall");

    // randomized batches, max_iter changed only with the pipe empty
    for (int b = 0; b < 3; b++) begin
      max_iter = ITER_W'($urandom_range(1, 255));
      accepted = 0;
      cyc = 0;
      in_valid = 1'b0;
      while (accepted < 150 && cyc < 5000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        fire = in_valid && in_ready;
        if (fire) accepted++;
        @(posedge clk);
        #1;
        if (!in_valid || fire) begin
          in_valid = ($urandom_range(0, 4) != 0);
          rnd_point();
        end
        cyc++;
      end
      check("batch_accepted", PW'(accepted), PW'(150));
      drain("drain_batch");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
